asi_w: RTL and testbench
========================

Name: asi_w

Overview:
- AXI4 slave (responder) write path; the far end of the DMA-write master in this codebase.
- Accepts one AW burst at a time, accepts its W beats, and drives each beat onto a simple user memory write port with a per-beat byte address.
- Returns one B response per burst.
- Sits in front of on-chip SRAM or register banks, and serves as the bench target for the DMA master.

Parameters:
AXI_DW, 128, AXI data bus width
AXI_AW, 32, AXI address width
AXI_IW, 8, ID width
AXI_LW, 8, AWLEN width
AXI_SW, 3, AWSIZE width
AXI_BURSTW, 2, AWBURST width
AXI_BRESPW, 2, BRESP width
AXI_BYTES, AXI_DW/8, bytes per beat (derived)
L, $clog2(AXI_BYTES), log2 of the maximum legal AWSIZE (derived)

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
AWID  in  AXI_IW  write burst ID
AWADDR  in  AXI_AW  burst start byte address
AWLEN  in  AXI_LW  beats minus 1
AWSIZE  in  AXI_SW  log2 bytes per beat
AWBURST  in  AXI_BURSTW  0 FIXED, 1 INCR, 2 WRAP
AWVALID  in  1  AW valid
AWREADY  out  1  AW ready
WDATA  in  AXI_DW  write data
WSTRB  in  AXI_BYTES  byte strobes
WLAST  in  1  last beat flag from master
WVALID  in  1  W valid
WREADY  out  1  W ready
BID  out  AXI_IW  response ID
BRESP  out  AXI_BRESPW  0 OKAY, 2 SLVERR
BVALID  out  1  B valid
BREADY  in  1  B ready
usr_we  out  1  user write strobe, one per accepted beat
usr_waddr  out  AXI_AW  byte address of the current beat
usr_wdata  out  AXI_DW  equals WDATA
usr_wstrb  out  AXI_BYTES  equals WSTRB
usr_wlast  out  1  high on the final beat per AWLEN
usr_wready  in  1  user backpressure

Behaviour:
- Clock and reset: single clock ACLK; reset ARESET is asynchronous and active-high.
- Reset values:
  - state IDLE
  - AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0
  - beat counter 0, error flag 0, all latched AW fields 0
  - usr_we=0 (it is combinational and gated by state).
- FSM states: IDLE, DATA, RESP.
- IDLE:
  - AWREADY=1.
  - On AWVALID&AWREADY: latch ID, ADDR, LEN, SIZE and BURST; clear counter and error flag; go to DATA next cycle.
  - W is never accepted in IDLE, even when WVALID arrives before AW.
- DATA:
  - AWREADY=0.
  - WREADY = usr_wready; usr_we = WVALID & WREADY.
  - usr_waddr = current beat address register (zero-latency pass-through of data and strobes).
  - Each W handshake increments the beat counter and advances the address.
  - The beat where counter==LEN ends the burst and moves to RESP. AWLEN is authoritative.
  - usr_wlast = (counter==LEN).
- WLAST checking:
  - If WLAST disagrees with (counter==LEN) on any beat, set the error flag.
  - The beat is still written.
- Illegal bursts (any of the following):
  - AWSIZE > L
  - AWBURST==3
  - WRAP with LEN not in {1,3,7,15}
  - Effect: set the error flag at AW acceptance. All beats are accepted (WREADY=1, ignoring usr_wready), usr_we is held 0, and the response is SLVERR.
- RESP:
  - BVALID=1; BID = latched ID; BRESP = error flag ? 2'b10 : 2'b00.
  - Outputs are held stable until BREADY.
  - On the handshake go to IDLE, so AWREADY=1 the following cycle.
  - Throughput: minimum burst overhead is 1 AW cycle + (LEN+1) beats + 1 B cycle.
- Address arithmetic, with sz = 1<<SIZE:
  - All sums are modulo 2^AXI_AW.
  - First beat uses the unaligned AWADDR as given.
  - FIXED: the address never changes.
  - INCR: next = (addr & ~(sz-1)) + sz.
  - WRAP: total = sz*(LEN+1); next = (addr & ~(total-1)) | ((addr+sz) & (total-1)). WRAP start addresses are required aligned to sz.
  - No 4KB-boundary checking; that is the master's obligation.
- Reset mid-burst:
  - Immediately return to IDLE and drop all outputs.
  - The partial burst is lost and no B response is issued.
- Simultaneous events: an AW presented while in DATA or RESP simply waits; only one burst is outstanding at a time.

Decomposition:
- Shared package asi_pkg:
  - burst type enum (FIXED/INCR/WRAP)
  - BRESP constants (OKAY, EXOKAY, SLVERR, DECERR)
  - FSM state enum
  - legal-WRAP-length check function
- One sub-module, asi_addr_gen: combinational next-address computation from addr, size, len and burst. It is reused later by the planned read-side slave.

Test Plan:
1. INCR: AWADDR=0x100, LEN=3, SIZE=4, ID=0x5A, WLAST on beat 3 -> usr_waddr 0x100, 0x110, 0x120, 0x130; usr_wlast on the 4th beat; BID=0x5A, BRESP=0.
2. WRAP: AWADDR=0x1030, LEN=3, SIZE=4 -> addresses 0x1030, 0x1000, 0x1010, 0x1020; BRESP=0.
3. FIXED with usr_wready toggling 1,0,1,0: AWADDR=0x40, LEN=2 -> three writes, all at 0x40; WREADY follows usr_wready; no beat dropped or duplicated.
4. WLAST early on beat 1 of LEN=3 -> 4 beats written; BRESP=2'b10.
5. AWSIZE=5 on a 128-bit bus -> 4 beats accepted, usr_we never asserted, BRESP=2'b10.
6. ARESET pulse after beat 1 of LEN=7, then a new AW with LEN=0 -> no B for the aborted burst; one B for the new burst, BRESP=0, with BREADY held low 3 cycles and BVALID/BID stable throughout.

Source files
------------

// File: rtl/asi_pkg.sv
// Shared types and helpers for the AXI4 slave write path (and the planned read path).
// Burst encodings, response codes, FSM states and the WRAP-length legality check.
package asi_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2
   } burst_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // WRAP bursts are only defined for 2, 4, 8 or 16 beats
   function automatic logic wrap_len_ok(input logic [31:0] len);
      return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
   endfunction

endpackage

// File: rtl/asi_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
// Shared between the write-side and the planned read-side slave.
module asi_addr_gen
   import asi_pkg::*;
#(
   parameter int AXI_AW     = 32,
   parameter int AXI_LW     = 8,
   parameter int AXI_SW     = 3,
   parameter int AXI_BURSTW = 2
) (
   input  logic [AXI_AW-1:0]     addr,
   input  logic [AXI_SW-1:0]     size,
   input  logic [AXI_LW-1:0]     len,
   input  logic [AXI_BURSTW-1:0] burst,
   output logic [AXI_AW-1:0]     next_addr
);

   logic [AXI_AW-1:0] sz_s;
   logic [AXI_AW-1:0] total_s;
   logic [AXI_AW-1:0] beats_s;

   assign sz_s    = AXI_AW'(1) << size;
   assign beats_s = AXI_AW'(len) + AXI_AW'(1);
   assign total_s = sz_s * beats_s;

   // next address; arithmetic wraps modulo 2^AXI_AW by construction
   always_comb begin
      next_addr = addr;
      case (burst)
         AXI_BURSTW'(BURST_FIXED): next_addr = addr;
         AXI_BURSTW'(BURST_INCR):  next_addr = (addr & ~(sz_s - AXI_AW'(1))) + sz_s;
         AXI_BURSTW'(BURST_WRAP):  next_addr = (addr & ~(total_s - AXI_AW'(1)))
                                             | ((addr + sz_s) & (total_s - AXI_AW'(1)));
         default:                  next_addr = addr;
      endcase
   end

endmodule

// File: rtl/asi_w.sv
// AXI4 slave write path: one burst at a time onto a simple user write port,
// one B response per burst; malformed bursts are drained and answered SLVERR.
module asi_w
   import asi_pkg::*;
#(
   parameter int AXI_DW     = 128,
   parameter int AXI_AW     = 32,
   parameter int AXI_IW     = 8,
   parameter int AXI_LW     = 8,
   parameter int AXI_SW     = 3,
   parameter int AXI_BURSTW = 2,
   parameter int AXI_BRESPW = 2,
   parameter int AXI_BYTES  = AXI_DW / 8,
   parameter int L          = $clog2(AXI_BYTES)
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic [AXI_IW-1:0]     AWID,
   input  logic [AXI_AW-1:0]     AWADDR,
   input  logic [AXI_LW-1:0]     AWLEN,
   input  logic [AXI_SW-1:0]     AWSIZE,
   input  logic [AXI_BURSTW-1:0] AWBURST,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [AXI_DW-1:0]     WDATA,
   input  logic [AXI_BYTES-1:0]  WSTRB,
   input  logic                  WLAST,
   input  logic                  WVALID,
   output logic                  WREADY,
   output logic [AXI_IW-1:0]     BID,
   output logic [AXI_BRESPW-1:0] BRESP,
   output logic                  BVALID,
   input  logic                  BREADY,
   output logic                  usr_we,
   output logic [AXI_AW-1:0]     usr_waddr,
   output logic [AXI_DW-1:0]     usr_wdata,
   output logic [AXI_BYTES-1:0]  usr_wstrb,
   output logic                  usr_wlast,
   input  logic                  usr_wready
);

   state_e                  state_r, state_s;
   logic                    awready_r;
   logic [AXI_IW-1:0]       id_r;
   logic [AXI_AW-1:0]       addr_r;
   logic [AXI_LW-1:0]       len_r;
   logic [AXI_SW-1:0]       size_r;
   logic [AXI_BURSTW-1:0]   burst_r;
   logic [AXI_LW-1:0]       cnt_r;
   logic                    err_r;
   logic                    ill_r;
   logic                    bvalid_r;
   logic [AXI_IW-1:0]       bid_r;
   logic [AXI_BRESPW-1:0]   bresp_r;

   logic                    aw_hs_s;
   logic                    w_hs_s;
   logic                    wready_s;
   logic                    last_s;
   logic                    wlast_err_s;
   logic                    ill_aw_s;
   logic [AXI_AW-1:0]       next_addr_s;

   asi_addr_gen #(
      .AXI_AW     (AXI_AW),
      .AXI_LW     (AXI_LW),
      .AXI_SW     (AXI_SW),
      .AXI_BURSTW (AXI_BURSTW)
   ) u_addr_gen (
      .addr      (addr_r),
      .size      (size_r),
      .len       (len_r),
      .burst     (burst_r),
      .next_addr (next_addr_s)
   );

   assign ill_aw_s = (AWSIZE > AXI_SW'(L))
                   || (AWBURST == AXI_BURSTW'(3))
                   || ((AWBURST == AXI_BURSTW'(BURST_WRAP)) && !wrap_len_ok(32'(AWLEN)));

   assign aw_hs_s     = (state_r == ST_IDLE) && AWVALID && awready_r;
   assign last_s      = (cnt_r == len_r);
   assign w_hs_s      = (state_r == ST_DATA) && WVALID && wready_s;
   assign wlast_err_s = (WLAST != last_s);

   // State register
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and W-channel ready; illegal bursts drain regardless of the user side
   always_comb begin
      state_s  = state_r;
      wready_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (aw_hs_s) begin
               state_s = ST_DATA;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DATA: begin
            wready_s = ill_r ? 1'b1 : usr_wready;
            if (WVALID && wready_s && last_s) begin
               state_s = ST_RESP;
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_RESP: begin
            if (BREADY) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Burst context, beat counter, error tracking and B-channel registers
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         awready_r <= 1'b0;
         id_r      <= '0;
         addr_r    <= '0;
         len_r     <= '0;
         size_r    <= '0;
         burst_r   <= '0;
         cnt_r     <= '0;
         err_r     <= 1'b0;
         ill_r     <= 1'b0;
         bvalid_r  <= 1'b0;
         bid_r     <= '0;
         bresp_r   <= '0;
      end else begin
         awready_r <= (state_s == ST_IDLE);
         if (aw_hs_s) begin
            id_r    <= AWID;
            addr_r  <= AWADDR;
            len_r   <= AWLEN;
            size_r  <= AWSIZE;
            burst_r <= AWBURST;
            cnt_r   <= '0;
            err_r   <= ill_aw_s;
            ill_r   <= ill_aw_s;
         end else if (w_hs_s) begin
            cnt_r  <= cnt_r + AXI_LW'(1);
            addr_r <= next_addr_s;
            err_r  <= err_r | wlast_err_s;
            if (last_s) begin
               bvalid_r <= 1'b1;
               bid_r    <= id_r;
               bresp_r  <= (err_r | wlast_err_s) ? AXI_BRESPW'(RESP_SLVERR)
                                                 : AXI_BRESPW'(RESP_OKAY);
            end
         end else if ((state_r == ST_RESP) && BREADY) begin
            bvalid_r <= 1'b0;
         end
      end
   end

   assign AWREADY   = awready_r;
   assign WREADY    = wready_s;
   assign BVALID    = bvalid_r;
   assign BID       = bid_r;
   assign BRESP     = bresp_r;
   assign usr_we    = w_hs_s && !ill_r;
   assign usr_waddr = addr_r;
   assign usr_wdata = WDATA;
   assign usr_wstrb = WSTRB;
   assign usr_wlast = (state_r == ST_DATA) && last_s;

endmodule

// File: tb/tb_asi_w.sv
// Self-checking bench for asi_w: scoreboard queues of expected user writes and
// B responses, filled when a burst is issued and drained as the DUT produces them.
module tb_asi_w;

   logic          ACLK = 1'b0;
   logic          ARESET;
   logic [7:0]    AWID;
   logic [31:0]   AWADDR;
   logic [7:0]    AWLEN;
   logic [2:0]    AWSIZE;
   logic [1:0]    AWBURST;
   logic          AWVALID;
   logic          AWREADY;
   logic [127:0]  WDATA;
   logic [15:0]   WSTRB;
   logic          WLAST;
   logic          WVALID;
   logic          WREADY;
   logic [7:0]    BID;
   logic [1:0]    BRESP;
   logic          BVALID;
   logic          BREADY;
   logic          usr_we;
   logic [31:0]   usr_waddr;
   logic [127:0]  usr_wdata;
   logic [15:0]   usr_wstrb;
   logic          usr_wlast;
   logic          usr_wready;

   int checks   = 0;
   int failures = 0;

   typedef struct { logic [31:0] addr; logic last; } wexp_t;
   typedef struct { logic [7:0] id; logic [1:0] resp; } bexp_t;
   wexp_t exp_w[$];
   bexp_t exp_b[$];

   always #5 ACLK = ~ACLK;

   asi_w dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .usr_we(usr_we), .usr_waddr(usr_waddr), .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb),
      .usr_wlast(usr_wlast), .usr_wready(usr_wready)
   );

   // Reference address sequence written in modulo form
   function automatic logic [31:0] model_next(input logic [31:0] a, input int size,
                                              input int len, input int burst);
      logic [31:0] sz, total, base;
      sz = 32'd1 << size;
      case (burst)
         1: return (a - (a % sz)) + sz;
         2: begin
            total = sz * (len + 1);
            base  = a - (a % total);
            return base + ((a + sz - base) % total);
         end
         default: return a;
      endcase
   endfunction

   task automatic push_burst(input logic [7:0] id, input logic [31:0] addr, input int len,
                             input int size, input int burst, input bit ill, input bit err);
      logic [31:0] a;
      wexp_t w;
      bexp_t b;
      a = addr;
      if (!ill) begin
         for (int i = 0; i <= len; i++) begin
            w.addr = a;
            w.last = (i == len);
            exp_w.push_back(w);
            a = model_next(a, size, len, burst);
         end
      end
      b.id   = id;
      b.resp = (ill || err) ? 2'b10 : 2'b00;
      exp_b.push_back(b);
   endtask

   task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input int len,
                        input int size, input int burst);
      int n;
      AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
      AWVALID = 1'b1;
      n = 0;
      @(negedge ACLK);
      while (!AWREADY && n < 50) begin
         @(negedge ACLK);
         n++;
      end
      checks++;
      if (!AWREADY) begin
         failures++;
         $display("FAIL aw_timeout: AWREADY=%b required 1", AWREADY);
      end
      @(posedge ACLK); #1;
      AWVALID = 1'b0;
   endtask

   task automatic do_w(input int nbeats, input int wlast_at, input bit ill,
                       input bit toggle, input bit rdy);
      int cyc;
      int n;
      bit done;
      logic exp_rdy;
      wexp_t w;
      cyc = 0;
      for (int i = 0; i < nbeats; i++) begin
         WVALID = 1'b1;
         WDATA  = {$urandom, $urandom, $urandom, $urandom};
         WSTRB  = 16'($urandom);
         WLAST  = (i == wlast_at);
         n = 0;
         done = 0;
         while (!done) begin
            usr_wready = toggle ? (cyc % 2 == 0) : rdy;
            cyc++;
            @(negedge ACLK);
            exp_rdy = ill ? 1'b1 : usr_wready;
            checks++;
            if (WREADY !== exp_rdy) begin
               failures++;
               $display("FAIL wready beat%0d: got %b required %b", i, WREADY, exp_rdy);
            end
            if (WREADY === 1'b1) begin
               done = 1;
               checks++;
               if (ill) begin
                  if (usr_we !== 1'b0) begin
                     failures++;
                     $display("FAIL usr_we_illegal beat%0d: got %b required 0", i, usr_we);
                  end
               end else if (usr_we !== 1'b1) begin
                  failures++;
                  $display("FAIL usr_we beat%0d: got %b required 1", i, usr_we);
               end else if (exp_w.size() == 0) begin
                  failures++;
                  $display("FAIL extra_write beat%0d: addr %h with no expected write", i, usr_waddr);
               end else begin
                  w = exp_w.pop_front();
                  checks++;
                  if (usr_waddr !== w.addr || usr_wlast !== w.last ||
                      usr_wdata !== WDATA || usr_wstrb !== WSTRB) begin
                     failures++;
                     $display("FAIL write beat%0d: addr %h last %b required addr %h last %b (data/strb pass %b)",
                              i, usr_waddr, usr_wlast, w.addr, w.last,
                              (usr_wdata === WDATA) && (usr_wstrb === WSTRB));
                  end
               end
            end else begin
               checks++;
               if (usr_we !== 1'b0) begin
                  failures++;
                  $display("FAIL usr_we_stalled beat%0d: got %b required 0", i, usr_we);
               end
            end
            n++;
            if (!done && n > 20) begin
               failures++;
               $display("FAIL w_timeout beat%0d: WREADY never seen", i);
               done = 1;
            end
            @(posedge ACLK); #1;
         end
      end
      WVALID = 1'b0;
      WLAST  = 1'b0;
   endtask

   task automatic do_b(input int hold);
      int n;
      bexp_t b;
      if (exp_b.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL b_scoreboard: no expected response queued");
         return;
      end
      b = exp_b.pop_front();
      BREADY = 1'b0;
      n = 0;
      @(negedge ACLK);
      while (!BVALID && n < 50) begin
         @(negedge ACLK);
         n++;
      end
      checks++;
      if (BVALID !== 1'b1 || BID !== b.id || BRESP !== b.resp) begin
         failures++;
         $display("FAIL bresp: BVALID %b BID %h BRESP %b required 1 %h %b", BVALID, BID, BRESP, b.id, b.resp);
      end
      for (int k = 0; k < hold; k++) begin
         @(negedge ACLK);
         checks++;
         if (BVALID !== 1'b1 || BID !== b.id || BRESP !== b.resp) begin
            failures++;
            $display("FAIL b_hold%0d: BVALID %b BID %h BRESP %b required 1 %h %b", k, BVALID, BID, BRESP, b.id, b.resp);
         end
      end
      @(posedge ACLK); #1;
      BREADY = 1'b1;
      @(posedge ACLK); #1;
      BREADY = 1'b0;
      @(negedge ACLK);
      checks++;
      if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin
         failures++;
         $display("FAIL b_done: BVALID %b AWREADY %b required 0 1", BVALID, AWREADY);
      end
      @(posedge ACLK); #1;
   endtask

   task automatic test_reset;
      ARESET = 1'b1;
      AWVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0; usr_wready = 1'b1;
      AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; WDATA = '0; WSTRB = '0;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      checks++;
      if (AWREADY !== 1'b0 || WREADY !== 1'b0 || BVALID !== 1'b0 || BID !== 8'h00 ||
          BRESP !== 2'b00 || usr_we !== 1'b0) begin
         failures++;
         $display("FAIL reset: AWREADY %b WREADY %b BVALID %b BID %h BRESP %b usr_we %b required all 0",
                  AWREADY, WREADY, BVALID, BID, BRESP, usr_we);
      end
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      @(posedge ACLK); #1;
   endtask

   task automatic test_incr;
      push_burst(8'h5A, 32'h100, 3, 4, 1, 0, 0);
      WVALID = 1'b1;
      @(negedge ACLK);
      checks++;
      if (WREADY !== 1'b0 || usr_we !== 1'b0) begin
         failures++;
         $display("FAIL w_before_aw: WREADY %b usr_we %b required 0 0", WREADY, usr_we);
      end
      @(posedge ACLK); #1;
      do_aw(8'h5A, 32'h100, 3, 4, 1);
      do_w(4, 3, 0, 0, 1);
      do_b(0);
   endtask

   task automatic test_wrap;
      push_burst(8'h21, 32'h1030, 3, 4, 2, 0, 0);
      do_aw(8'h21, 32'h1030, 3, 4, 2);
      do_w(4, 3, 0, 0, 1);
      do_b(0);
   endtask

   task automatic test_fixed_backpressure;
      push_burst(8'h07, 32'h40, 2, 4, 0, 0, 0);
      do_aw(8'h07, 32'h40, 2, 4, 0);
      do_w(3, 2, 0, 1, 1);
      usr_wready = 1'b1;
      do_b(0);
   endtask

   task automatic test_wlast_early;
      push_burst(8'h3C, 32'h200, 3, 4, 1, 0, 1);
      do_aw(8'h3C, 32'h200, 3, 4, 1);
      do_w(4, 1, 0, 0, 1);
      do_b(0);
   endtask

   task automatic test_illegal_size;
      push_burst(8'h99, 32'h300, 3, 5, 1, 1, 0);
      do_aw(8'h99, 32'h300, 3, 5, 1);
      do_w(4, 3, 1, 0, 0);
      usr_wready = 1'b1;
      do_b(1);
   endtask

   task automatic test_reset_abort;
      push_burst(8'hAB, 32'h400, 7, 4, 1, 0, 0);
      do_aw(8'hAB, 32'h400, 7, 4, 1);
      do_w(2, 7, 0, 0, 1);
      ARESET = 1'b1;
      #1;
      checks++;
      if (AWREADY !== 1'b0 || WREADY !== 1'b0 || BVALID !== 1'b0 || usr_we !== 1'b0) begin
         failures++;
         $display("FAIL abort_reset: AWREADY %b WREADY %b BVALID %b usr_we %b required 0", AWREADY, WREADY, BVALID, usr_we);
      end
      exp_w.delete();
      exp_b.delete();
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      repeat (3) begin
         @(negedge ACLK);
         checks++;
         if (BVALID !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_b: BVALID %b required 0", BVALID);
         end
      end
      @(posedge ACLK); #1;
      push_burst(8'h33, 32'h500, 0, 4, 1, 0, 0);
      do_aw(8'h33, 32'h500, 0, 4, 1);
      do_w(1, 0, 0, 0, 1);
      do_b(3);
   endtask

   initial begin
      test_reset;
      test_incr;
      test_wrap;
      test_fixed_backpressure;
      test_wlast_early;
      test_illegal_size;
      test_reset_abort;
      checks++;
      if (exp_w.size() != 0 || exp_b.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: writes left %0d responses left %0d required 0 0", exp_w.size(), exp_b.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
